trees_job_ctrl: RTL

Job sequencer in front of the tree-ensemble ping-pong accelerator. It accepts a job descriptor, streams an optional model image and a feature burst from one 64-bit valid/ready input stream into the accelerator's write ports, and generates their addresses. It then pulses start, waits for done, and drains packed predictions onto a 64-bit valid/ready output stream. It is the only master of the accelerator's load, start and read ports.

---
 rtl/trees_ctrl_pkg.sv | 38 +++
 rtl/trees_stream_addr_gen.sv | 34 +++
 rtl/trees_job_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/trees_ctrl_pkg.sv
// Shared types, widths and word-count helpers for the tree-ensemble job sequencer.
package trees_ctrl_pkg;

   localparam int N_TREES          = 16;
   localparam int N_NODE_AND_LEAFS = 256;
   localparam int N_FEATURE        = 32;
   localparam int MAX_BURST        = 5000;
   localparam int PREDS_PER_WORD   = 8;

   localparam int BURST_W = $clog2(MAX_BURST) + 1;
   localparam int FADDR_W = $clog2(MAX_BURST * N_FEATURE / 2);
   localparam int NODE_W  = $clog2(N_NODE_AND_LEAFS);
   localparam int TREE_W  = $clog2(N_TREES);
   localparam int CNT_W   = FADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_MODEL,
      LOAD_FEAT,
      START,
      RUN,
      SETTLE,
      DRAIN
   } job_state_t;

   function automatic logic [CNT_W-1:0] model_words();
      return CNT_W'(N_TREES * N_NODE_AND_LEAFS);
   endfunction

   function automatic logic [CNT_W-1:0] feat_words(input logic [BURST_W-1:0] burst);
      return CNT_W'(burst) * CNT_W'(N_FEATURE / 2);
   endfunction

   function automatic logic [CNT_W-1:0] pred_words(input logic [BURST_W-1:0] burst);
      return (CNT_W'(burst) + CNT_W'(PREDS_PER_WORD - 1)) / CNT_W'(PREDS_PER_WORD);
   endfunction

endpackage

// File: rtl/trees_stream_addr_gen.sv
// Loadable word counter with a last-word flag; one instance serves the model,
// feature and prediction phases in turn.
module trees_stream_addr_gen
   import trees_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_last,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_last;

   // Load restarts the count at zero with a new terminal index; otherwise step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_last <= '0;
      end else if (i_load) begin
         r_cnt  <= '0;
         r_last <= i_last;
      end else if (i_inc) begin
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == r_last);

endmodule

// File: rtl/trees_job_ctrl.sv
// Job sequencer: loads model/features into the accelerator, starts it and drains predictions.
// Optional cycle counters enabled with TREES_JOB_CTRL_PERF_EN.
module trees_job_ctrl
   import trees_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic               cfg_load_model,
   input  logic [BURST_W-1:0] cfg_burst_len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [63:0]        in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_data,
   output logic               busy,
   output logic               err,
   output logic               acc_load_trees,
   output logic [NODE_W-1:0]  acc_n_node,
   output logic [TREE_W-1:0]  acc_n_tree,
   output logic [63:0]        acc_tree_nodes,
   output logic               acc_load_features,
   output logic [FADDR_W-1:0] acc_feature_addr,
   output logic [63:0]        acc_features2,
   output logic [BURST_W-1:0] acc_burst_len,
   output logic               acc_start,
   input  logic               acc_done,
   output logic [BURST_W-1:0] acc_prediction_addr,
   input  logic [63:0]        acc_prediction
`ifdef TREES_JOB_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_run_cycles,
   output logic [31:0]        perf_stall_cycles
`endif
);

   job_state_t       r_state;
   logic [BURST_W-1:0] r_burst;
   logic             r_err;

   logic             w_cfg_ok;
   logic             w_load;
   logic             w_inc;
   logic [CNT_W-1:0] w_last_val;
   logic [CNT_W-1:0] w_cnt;
   logic             w_last;
   logic             w_in_model;
   logic             w_in_feat;
   logic             w_drain;

   assign w_cfg_ok = (cfg_burst_len != BURST_W'(0)) && (cfg_burst_len <= BURST_W'(MAX_BURST));

   trees_stream_addr_gen u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_last (w_last_val),
      .i_inc  (w_inc),
      .o_cnt  (w_cnt),
      .o_last (w_last)
   );

   // Counter is reloaded at each phase entry with that phase's last word index.
   always_comb begin
      w_load     = 1'b0;
      w_inc      = 1'b0;
      w_last_val = '0;
      case (r_state)
         IDLE: begin
            if (cfg_valid && w_cfg_ok) begin
               w_load     = 1'b1;
               w_last_val = cfg_load_model ? (model_words() - CNT_W'(1))
                                           : (feat_words(cfg_burst_len) - CNT_W'(1));
            end else begin
               w_load = 1'b0;
            end
         end
         LOAD_MODEL: begin
            if (in_valid && w_last) begin
               w_load     = 1'b1;
               w_last_val = feat_words(r_burst) - CNT_W'(1);
            end else begin
               w_inc = in_valid;
            end
         end
         LOAD_FEAT: w_inc = in_valid && !w_last;
         SETTLE: begin
            w_load     = 1'b1;
            w_last_val = pred_words(r_burst) - CNT_W'(1);
         end
         DRAIN:   w_inc = out_ready && !w_last;
         default: w_inc = 1'b0;
      endcase
   end

   // Job state machine; err is a registered one-cycle pulse for a rejected descriptor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_burst <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cfg_valid) begin
                  if (w_cfg_ok) begin
                     r_burst <= cfg_burst_len;
                     r_state <= cfg_load_model ? LOAD_MODEL : LOAD_FEAT;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            LOAD_MODEL: if (in_valid && w_last) r_state <= LOAD_FEAT;
            LOAD_FEAT:  if (in_valid && w_last) r_state <= START;
            START:      r_state <= RUN;
            RUN:        if (acc_done) r_state <= SETTLE;
            SETTLE:     r_state <= DRAIN;
            DRAIN:      if (out_ready && w_last) r_state <= IDLE;
            default:    r_state <= IDLE;
         endcase
      end
   end

   assign w_in_model = (r_state == LOAD_MODEL);
   assign w_in_feat  = (r_state == LOAD_FEAT);
   assign w_drain    = (r_state == DRAIN);

   assign cfg_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign err       = r_err;
   assign in_ready  = w_in_model || w_in_feat;

   // Address/data ports are forced to zero outside their phase so idle outputs stay quiet.
   assign acc_load_trees      = w_in_model && in_valid;
   assign acc_n_tree          = w_in_model ? w_cnt[NODE_W +: TREE_W] : '0;
   assign acc_n_node          = w_in_model ? w_cnt[NODE_W-1:0] : '0;
   assign acc_tree_nodes      = w_in_model ? in_data : '0;
   assign acc_load_features   = w_in_feat && in_valid;
   assign acc_feature_addr    = w_in_feat ? w_cnt : '0;
   assign acc_features2       = w_in_feat ? in_data : '0;
   assign acc_burst_len       = r_burst;
   assign acc_start           = (r_state == START);
   assign out_valid           = w_drain;
   assign out_data            = w_drain ? acc_prediction : '0;
   assign acc_prediction_addr = w_drain ? w_cnt[BURST_W-1:0] : '0;

`ifdef TREES_JOB_CTRL_PERF_EN
   logic [31:0] r_perf_run;
   logic [31:0] r_perf_stall;

   // Cleared on each accepted descriptor and held once the job returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_run   <= 32'd0;
         r_perf_stall <= 32'd0;
      end else if ((r_state == IDLE) && cfg_valid && w_cfg_ok) begin
         r_perf_run   <= 32'd0;
         r_perf_stall <= 32'd0;
      end else begin
         if (r_state == RUN) begin
            r_perf_run <= r_perf_run + 32'd1;
         end
         if (((w_in_model || w_in_feat) && !in_valid) || (w_drain && !out_ready)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_run_cycles   = r_perf_run;
   assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
